// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Moore-style datapath strobes are decoded from the current state.
// A watchdog aborts memory waits that last too long.
// A counter tracks retired instructions.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             mem_ready,
  output logic [1:0]       AluOp,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       PcSrc,
  output logic             PcWrite,
  output logic             PcWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // The watchdog counter only needs to reach MEM_TIMEOUT-1.
  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t           state_reg, state_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic [CNT_W-1:0] retired_reg, retired_next;
  logic             mem_state;
  logic             timeout_hit;
  logic             retire_src;

  // Register state, watchdog and retired counter; reset aborts any instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      wdog_reg    <= '0;
      retired_reg <= '0;
    end else begin
      state_reg   <= state_next;
      wdog_reg    <= wdog_next;
      retired_reg <= retired_next;
    end
  end

  // Next state, watchdog and retire logic, plus strobes that are forced low during reset.
  always_comb begin
    state_next   = state_reg;
    AluOp        = 2'b00;
    AluSrcA      = 1'b0;
    AluSrcB      = 2'b00;
    PcSrc        = 2'b00;
    PcWrite      = 1'b0;
    PcWriteCond  = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    illegal_op   = 1'b0;
    mem_timeout  = 1'b0;

    mem_state   = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !mem_ready && (wdog_reg == WD_LAST);

    case (state_reg)
      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'b01;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PcWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        AluSrcB = 2'b11;
        case (Opcode)
          OP_R:         state_next = S_EXEC;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC: begin
        AluSrcA    = 1'b1;
        AluOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        AluSrcA     = 1'b1;
        AluOp       = 2'b01;
        PcWriteCond = 1'b1;
        PcSrc       = 2'b01;
        state_next  = S_FETCH;
      end
      S_ADDIEX: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PcWrite    = 1'b1;
        PcSrc      = 2'b10;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    // A watchdog abort overrides the normal transition; strobes stay as decoded.
    if (timeout_hit) begin
      mem_timeout = 1'b1;
      state_next  = S_FETCH;
    end

    // Count instructions that complete normally into FETCH.
    retire_src = (state_reg == S_MEMWB) || (state_reg == S_MEMWR) || (state_reg == S_ALUWB) ||
                 (state_reg == S_BRANCH) || (state_reg == S_ADDIWB) || (state_reg == S_JUMP);
    retired_next = retired_reg;
    if (retire_src && (state_next == S_FETCH) && !timeout_hit)
      retired_next = retired_reg + 1'b1;

    wdog_next = wdog_reg;
    if ((MEM_TIMEOUT == 0) || timeout_hit || (state_next != state_reg) || mem_ready)
      wdog_next = '0;
    else if (mem_state)
      wdog_next = wdog_reg + 1'b1;

    if (reset) begin
      AluOp       = 2'b00;
      AluSrcA     = 1'b0;
      AluSrcB     = 2'b00;
      PcSrc       = 2'b00;
      PcWrite     = 1'b0;
      PcWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control FSM.
// Stimulus pushes hand-computed per-cycle expectations.
// A monitor pops them on the falling edge and compares.
module tb_mips_multicycle_control;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       Opcode;
  logic             mem_ready;
  logic [1:0]       AluOp;
  logic             AluSrcA;
  logic [1:0]       AluSrcB;
  logic [1:0]       PcSrc;
  logic             PcWrite, PcWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic             MemtoReg, RegDst, RegWrite, illegal_op, mem_timeout;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  mips_multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .mem_ready(mem_ready),
    .AluOp(AluOp), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PcSrc(PcSrc),
    .PcWrite(PcWrite), .PcWriteCond(PcWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  // Control word: {AluOp,AluSrcA,AluSrcB,PcSrc,PcWrite,PcWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,illegal_op,mem_timeout}
  function automatic logic [17:0] mk(input logic [1:0] aop, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic pw, input logic pwc,
                                     input logic iord, input logic mr, input logic mw, input logic irw,
                                     input logic m2r, input logic rd, input logic rw,
                                     input logic ill, input logic to);
    return {aop, sa, sb, ps, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, ill, to};
  endfunction

  typedef struct packed {
    logic [3:0]       st;
    logic [17:0]      ctrl;
    logic [CNT_W-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  logic [17:0] C_ZERO, C_FETCH, C_FWAIT, C_FTO, C_DEC, C_DECILL, C_MADR, C_MRD, C_MWB;
  logic [17:0] C_MWR, C_MWRTO, C_EXEC, C_ALUWB, C_BR, C_ADDIEX, C_ADDIWB, C_JUMP;

  initial begin
    C_ZERO   = '0;
    C_FETCH  = mk(2'b00,0,2'b01,2'b00,1,0,0,1,0,1,0,0,0,0,0);
    C_FWAIT  = mk(2'b00,0,2'b01,2'b00,0,0,0,1,0,0,0,0,0,0,0);
    C_FTO    = mk(2'b00,0,2'b01,2'b00,0,0,0,1,0,0,0,0,0,0,1);
    C_DEC    = mk(2'b00,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0,0,0);
    C_DECILL = mk(2'b00,0,2'b11,2'b00,0,0,0,0,0,0,0,0,0,1,0);
    C_MADR   = mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0,0,0);
    C_MRD    = mk(2'b00,0,2'b00,2'b00,0,0,1,1,0,0,0,0,0,0,0);
    C_MWB    = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,0,1,0,1,0,0);
    C_MWR    = mk(2'b00,0,2'b00,2'b00,0,0,1,0,1,0,0,0,0,0,0);
    C_MWRTO  = mk(2'b00,0,2'b00,2'b00,0,0,1,0,1,0,0,0,0,0,1);
    C_EXEC   = mk(2'b10,1,2'b00,2'b00,0,0,0,0,0,0,0,0,0,0,0);
    C_ALUWB  = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,0,0,1,1,0,0);
    C_BR     = mk(2'b01,1,2'b00,2'b01,0,1,0,0,0,0,0,0,0,0,0);
    C_ADDIEX = mk(2'b00,1,2'b10,2'b00,0,0,0,0,0,0,0,0,0,0,0);
    C_ADDIWB = mk(2'b00,0,2'b00,2'b00,0,0,0,0,0,0,0,0,1,0,0);
    C_JUMP   = mk(2'b00,0,2'b00,2'b10,1,0,0,0,0,0,0,0,0,0,0);
  end

  // Drive one cycle of inputs and queue the expected outputs for that cycle.
  task automatic step(input logic rst, input logic mr, input logic [5:0] op,
                      input logic [3:0] st, input logic [17:0] ctrl, input int ret);
    exp_t e;
    reset     = rst;
    mem_ready = mr;
    Opcode    = op;
    e.st   = st;
    e.ctrl = ctrl;
    e.ret  = CNT_W'(ret);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every queued expectation against the DUT on the falling edge.
  initial begin
    exp_t e;
    logic [17:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {AluOp, AluSrcA, AluSrcB, PcSrc, PcWrite, PcWriteCond, IorD, MemRead, MemWrite,
               IRWrite, MemtoReg, RegDst, RegWrite, illegal_op, mem_timeout};
        n_vec++;
        if (state !== e.st || act !== e.ctrl || retired !== e.ret) begin
          n_fail++;
          $display("FAIL vec%0d: state=%0d ctrl=%b retired=%0d, required state=%0d ctrl=%b retired=%0d",
                   n_vec, state, act, retired, e.st, e.ctrl, e.ret);
        end else begin
          $display("vec%0d ok: state=%0d ctrl=%b retired=%0d", n_vec, state, act, retired);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; mem_ready = 1'b1; Opcode = 6'b0;
    @(posedge clk);
    #1;
    // Reset for two cycles: everything quiet.
    step(1, 1, 6'b000000, 0, C_ZERO, 0);
    step(1, 1, 6'b000000, 0, C_ZERO, 0);
    // R-type.
    step(0, 1, 6'b000000, 0, C_FETCH, 0);
    step(0, 1, 6'b000000, 1, C_DEC,   0);
    step(0, 1, 6'b000000, 6, C_EXEC,  0);
    step(0, 1, 6'b000000, 7, C_ALUWB, 0);
    // lw with three wait cycles in MEMRD.
    step(0, 1, 6'b100011, 0, C_FETCH, 1);
    step(0, 1, 6'b100011, 1, C_DEC,   1);
    step(0, 1, 6'b100011, 2, C_MADR,  1);
    step(0, 0, 6'b100011, 3, C_MRD,   1);
    step(0, 0, 6'b100011, 3, C_MRD,   1);
    step(0, 0, 6'b100011, 3, C_MRD,   1);
    step(0, 1, 6'b100011, 3, C_MRD,   1);
    step(0, 1, 6'b100011, 4, C_MWB,   1);
    // beq.
    step(0, 1, 6'b000100, 0, C_FETCH, 2);
    step(0, 1, 6'b000100, 1, C_DEC,   2);
    step(0, 1, 6'b000100, 8, C_BR,    2);
    // j.
    step(0, 1, 6'b000010, 0, C_FETCH, 3);
    step(0, 1, 6'b000010, 1, C_DEC,   3);
    step(0, 1, 6'b000010, 11, C_JUMP, 3);
    // addi.
    step(0, 1, 6'b001000, 0, C_FETCH,   4);
    step(0, 1, 6'b001000, 1, C_DEC,     4);
    step(0, 1, 6'b001000, 9, C_ADDIEX,  4);
    step(0, 1, 6'b001000, 10, C_ADDIWB, 4);
    // sw, immediate completion.
    step(0, 1, 6'b101011, 0, C_FETCH, 5);
    step(0, 1, 6'b101011, 1, C_DEC,   5);
    step(0, 1, 6'b101011, 2, C_MADR,  5);
    step(0, 1, 6'b101011, 5, C_MWR,   5);
    // Illegal opcode: pulse in DECODE, back to FETCH, no retire.
    step(0, 1, 6'b111111, 0, C_FETCH,  6);
    step(0, 1, 6'b111111, 1, C_DECILL, 6);
    // sw that never completes: abort on the 4th MEMWR cycle.
    step(0, 1, 6'b101011, 0, C_FETCH, 6);
    step(0, 1, 6'b101011, 1, C_DEC,   6);
    step(0, 1, 6'b101011, 2, C_MADR,  6);
    step(0, 0, 6'b101011, 5, C_MWR,   6);
    step(0, 0, 6'b101011, 5, C_MWR,   6);
    step(0, 0, 6'b101011, 5, C_MWR,   6);
    step(0, 0, 6'b101011, 5, C_MWRTO, 6);
    // Stalled FETCH: abort restarts FETCH.
    step(0, 0, 6'b000000, 0, C_FWAIT, 6);
    step(0, 0, 6'b000000, 0, C_FWAIT, 6);
    step(0, 0, 6'b000000, 0, C_FWAIT, 6);
    step(0, 0, 6'b000000, 0, C_FTO,   6);
    // Two R-types to wrap the 3-bit retired counter 7 -> 0.
    step(0, 1, 6'b000000, 0, C_FETCH, 6);
    step(0, 1, 6'b000000, 1, C_DEC,   6);
    step(0, 1, 6'b000000, 6, C_EXEC,  6);
    step(0, 1, 6'b000000, 7, C_ALUWB, 6);
    step(0, 1, 6'b000000, 0, C_FETCH, 7);
    step(0, 1, 6'b000000, 1, C_DEC,   7);
    step(0, 1, 6'b000000, 6, C_EXEC,  7);
    step(0, 1, 6'b000000, 7, C_ALUWB, 7);
    // Reset in the middle of an R-type, then a clean FETCH.
    step(0, 1, 6'b000000, 0, C_FETCH, 0);
    step(0, 1, 6'b000000, 1, C_DEC,   0);
    step(1, 1, 6'b000000, 6, C_ZERO,  0);
    step(0, 1, 6'b000000, 0, C_FETCH, 0);
    stim_done = 1'b1;
  end

  // Wait for the monitor to drain the queue, bounded in cycles.
  initial begin
    wait (stim_done);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
